// File: rtl/rv_hart_sched.sv
// Barrel-thread issue scheduler: walks the hart table ROM one slot per advancing
// cycle and issues the stored hart ID, or a bubble if that hart is not ready.
module rv_hart_sched #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int TABLE_LEN  = 8,
  parameter int PIPE_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_stall,
  input  logic                       i_restart,
  input  logic [2**DATA_WIDTH-1:0]   i_hart_active,
  output logic [ADDR_WIDTH-1:0]      o_h_addr,
  input  logic [DATA_WIDTH-1:0]      i_h_out,
  output logic                       o_issue_valid,
  output logic [DATA_WIDTH-1:0]      o_issue_hart,
  output logic [15:0]                o_bubble_cnt
);

  localparam int NUM_HARTS = 2**DATA_WIDTH;
  localparam int CD_W      = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_issueValid;
  logic [DATA_WIDTH-1:0] r_issueHart;
  logic [15:0]           r_bubbleCnt;
  logic [CD_W-1:0]       r_cooldown [NUM_HARTS];

  logic                  w_elig;
  logic [ADDR_WIDTH-1:0] w_ptrNext;

  assign w_elig    = i_hart_active[i_h_out] && (r_cooldown[i_h_out] == '0);
  assign w_ptrNext = (r_ptr == ADDR_WIDTH'(TABLE_LEN - 1)) ? '0 : r_ptr + 1'b1;

  // Priority is restart > stall > !en > advance; cooldowns count advancing
  // cycles (and drain cycles) until a hart may issue again.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr        <= '0;
      r_issueValid <= 1'b0;
      r_issueHart  <= '0;
      r_bubbleCnt  <= '0;
      for (int i = 0; i < NUM_HARTS; i++) r_cooldown[i] <= '0;
    end else if (i_restart) begin
      r_ptr        <= '0;
      r_issueValid <= 1'b0;
      for (int i = 0; i < NUM_HARTS; i++) r_cooldown[i] <= '0;
    end else if (i_stall) begin
      r_ptr <= r_ptr;
    end else if (!i_en) begin
      r_issueValid <= 1'b0;
      for (int i = 0; i < NUM_HARTS; i++)
        if (r_cooldown[i] != '0) r_cooldown[i] <= r_cooldown[i] - 1'b1;
    end else begin
      r_issueValid <= w_elig;
      r_issueHart  <= i_h_out;
      r_ptr        <= w_ptrNext;
      for (int i = 0; i < NUM_HARTS; i++)
        if (r_cooldown[i] != '0) r_cooldown[i] <= r_cooldown[i] - 1'b1;
      if (w_elig)
        r_cooldown[i_h_out] <= CD_W'(PIPE_DEPTH - 1);
      else if (r_bubbleCnt != 16'hFFFF)
        r_bubbleCnt <= r_bubbleCnt + 16'd1;
    end
  end

  assign o_h_addr      = r_ptr;
  assign o_issue_valid = r_issueValid;
  assign o_issue_hart  = r_issueHart;
  assign o_bubble_cnt  = r_bubbleCnt;

endmodule
